riscv_trace_buf: RTL and testbench

RISCV_TRACE_BUF -- requirements
Module: riscv_trace_buf

---
 rtl/riscv_trace_buf.sv | 176 +++++++++++++++++
 tb/tb_riscv_trace_buf.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_buf.sv
// Instruction trace buffer: taps one of NCH pipeline stages into a circular buffer, stops on trigger/post-count or go=0.
// Latency: capture written on the edge it is sampled; rd_data/rd_vld registered one cycle after rd_req.
// Backpressure: none on capture (oldest entry overwritten, overflow sticky); reads only honoured in FROZEN with count>0.
// Optional: define TRACE_TIMESTAMP_EN to store a 16-bit cycle stamp per entry and expose it on rd_ts.
module riscv_trace_buf #(
  parameter int IW    = 32,
  parameter int NCH   = 5,
  parameter int DEPTH = 16,
  parameter int POST  = 4,
  localparam int CSW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [CSW-1:0]     ch_sel,
  input  logic [NCH*IW-1:0]  inst_bus,
  input  logic [NCH-1:0]     inst_vld,
  input  logic               trig_en,
  input  logic [IW-1:0]      trig_inst,
  input  logic               rd_req,
  output logic [IW-1:0]      rd_data,
  output logic               rd_vld,
  output logic [CW-1:0]      count,
`ifdef TRACE_TIMESTAMP_EN
  output logic [15:0]        rd_ts,
`endif
  output logic [1:0]         state,
  output logic               overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  // Last value of the post-trigger counter before freezing (POST=0 never enters S_POST).
  localparam logic [CW-1:0] POST_LAST = CW'((POST > 0) ? POST - 1 : 0);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  state_t          st;
  logic [IW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   post_cnt;
  logic [CSW-1:0]  ch_sel_q;
  logic [IW-1:0]   cap_word;
  logic            cap_sel_vld;
  logic            capture;
  logic            full;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]     ts_q;
  logic [15:0]     ts_mem [DEPTH];
`endif

  assign state = st;
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);

  // Select the latched tap; an out-of-range select simply never captures.
  always_comb begin
    cap_word    = '0;
    cap_sel_vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel_q == k[CSW-1:0]) begin
        cap_word    = inst_bus[k*IW +: IW];
        cap_sel_vld = inst_vld[k];
      end
    end
  end

  assign capture = ((st == S_ARMED) || (st == S_POST)) && cap_sel_vld;

  // Trace storage: not reset, written on every accepted capture.
  always_ff @(posedge clk) begin
    if (reset && capture) begin
      mem[wptr] <= cap_word;
`ifdef TRACE_TIMESTAMP_EN
      ts_mem[wptr] <= ts_q;
`endif
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  // Cycle stamp: restarts at arming, runs freely (wrapping) until back in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q <= '0;
    end else if (st == S_IDLE) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 16'd1;
    end
  end

  // Stamp readout tracks rd_data on every honoured pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ts <= '0;
    end else if ((st == S_FROZEN) && rd_req && (count_q != '0)) begin
      rd_ts <= ts_mem[rptr];
    end
  end
`endif

  // Control FSM with pointer/count bookkeeping and registered read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st       <= S_IDLE;
      count_q  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      rd_vld   <= 1'b0;
      rd_data  <= '0;
      post_cnt <= '0;
      ch_sel_q <= '0;
    end else begin
      rd_vld <= 1'b0;
      case (st)
        S_IDLE: begin
          if (go) begin
            st       <= S_ARMED;
            ch_sel_q <= ch_sel;
            count_q  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            post_cnt <= '0;
          end
        end
        S_ARMED, S_POST: begin
          if (capture) begin
            wptr <= wptr + 1'b1;
            if (full) begin
              // Oldest entry is lost: read pointer follows the write pointer.
              rptr     <= rptr + 1'b1;
              overflow <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
          if (!go) begin
            st <= S_FROZEN;
          end else if (st == S_ARMED) begin
            if (capture && trig_en && (cap_word == trig_inst)) begin
              st <= (POST == 0) ? S_FROZEN : S_POST;
            end
          end else if (capture) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt == POST_LAST) begin
              st <= S_FROZEN;
            end
          end
        end
        S_FROZEN: begin
          if (rd_req && (count_q != '0)) begin
            rd_data <= mem[rptr];
            rd_vld  <= 1'b1;
            rptr    <= rptr + 1'b1;
            count_q <= count_q - 1'b1;
          end else if (!go && (count_q == '0)) begin
            st <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_trace_buf.sv
// Directed bench for riscv_trace_buf with a queue scoreboard of expected trace words.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a (bench drives reads explicitly).
module tb_riscv_trace_buf;
  localparam int IW    = 32;
  localparam int NCH   = 5;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              go;
  logic [2:0]        ch_sel;
  logic [NCH*IW-1:0] inst_bus;
  logic [NCH-1:0]    inst_vld;
  logic              trig_en;
  logic [IW-1:0]     trig_inst;
  logic              rd_req;
  logic [IW-1:0]     rd_data;
  logic              rd_vld;
  logic [4:0]        count;
  logic [1:0]        state;
  logic              overflow;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]       rd_ts;
`endif

  riscv_trace_buf dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .ch_sel    (ch_sel),
    .inst_bus  (inst_bus),
    .inst_vld  (inst_vld),
    .trig_en   (trig_en),
    .trig_inst (trig_inst),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld),
    .count     (count),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts     (rd_ts),
`endif
    .state     (state),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [IW-1:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [2:0] c);
    inst_vld = '0;
    go       = 1'b1;
    ch_sel   = c;
    tick();
    check("arm_state", 64'(state), 64'd1);
    check("arm_count", 64'(count), 64'd0);
  endtask

  // Drive one valid word on tap ch; scoreboard keeps the newest DEPTH words.
  task automatic capture(input int ch, input logic [IW-1:0] w);
    inst_vld = '0;
    inst_bus[ch*IW +: IW] = w;
    inst_vld[ch] = 1'b1;
    sb.push_back(w);
    if (sb.size() > DEPTH) void'(sb.pop_front());
    tick();
  endtask

  // Back-to-back pops: every cycle must return the next scoreboard entry.
  task automatic drain(input int n, input string tag);
    logic [IW-1:0] exp_w;
    rd_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_rd_vld"}, 64'(rd_vld), 64'd1);
      exp_w = (sb.size() > 0) ? sb.pop_front() : '1;
      check({tag, "_rd_data"}, 64'(rd_data), 64'(exp_w));
    end
    rd_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; ch_sel = '0; inst_bus = '0; inst_vld = '0;
    trig_en = 1'b0; trig_inst = '0; rd_req = 1'b0;
    tick(); tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_rd_vld", 64'(rd_vld), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    reset = 1'b1;
    tick();
    check("idle_hold", 64'(state), 64'd0);

    // Fill: 10 words on tap 4, no trigger.
    arm(3'd4);
    rd_req = 1'b1;             // ignored outside FROZEN
    tick();
    check("rd_armed_vld", 64'(rd_vld), 64'd0);
    check("rd_armed_state", 64'(state), 64'd1);
    rd_req = 1'b0;
    for (int i = 0; i < 10; i++) capture(4, 32'h100 + i);
    inst_vld = '0; go = 1'b0;
    tick();
    check("fill_state", 64'(state), 64'd3);
    check("fill_count", 64'(count), 64'd10);
    check("fill_overflow", 64'(overflow), 64'd0);
    drain(10, "fill");
    check("fill_empty", 64'(count), 64'd0);
    tick();
    check("fill_empty_rd_vld", 64'(rd_vld), 64'd0);
    check("fill_idle", 64'(state), 64'd0);

    // Wrap: 20 words into 16 entries.
    arm(3'd4);
    for (int i = 0; i < 20; i++) capture(4, 32'h200 + i);
    inst_vld = '0; go = 1'b0;
    tick();
    check("wrap_count", 64'(count), 64'd16);
    check("wrap_overflow", 64'(overflow), 64'd1);
    drain(16, "wrap");
    tick();
    check("wrap_idle", 64'(state), 64'd0);
    check("wrap_ovf_sticky", 64'(overflow), 64'd1);

    // Trigger on 0x13 after 0x305, then 4 post-trigger words.
    trig_en = 1'b1; trig_inst = 32'h13;
    arm(3'd4);
    check("arm_ovf_clear", 64'(overflow), 64'd0);
    for (int i = 0; i < 6; i++) capture(4, 32'h300 + i);
    check("pre_trig_state", 64'(state), 64'd1);
    capture(4, 32'h13);
    check("trig_state", 64'(state), 64'd2);
    for (int i = 0; i < 3; i++) capture(4, 32'h306 + i);
    check("post3_state", 64'(state), 64'd2);
    capture(4, 32'h309);
    check("post_frozen", 64'(state), 64'd3);
    inst_bus[4*IW +: IW] = 32'h999; // must not be written while frozen
    tick();
    inst_vld = '0;
    check("trig_count", 64'(count), 64'd11);
    drain(11, "trig");
    tick();
    check("frozen_go_hold", 64'(state), 64'd3);
    go = 1'b0;
    tick();
    check("trig_idle", 64'(state), 64'd0);
    trig_en = 1'b0;

    // Channel mux: only tap 2 is recorded.
    arm(3'd2);
    for (int i = 0; i < 4; i++) begin
      inst_bus[0 +: IW] = 32'hAAAA0000 + i;
      inst_vld = {4'b0, 1'(i % 2)};
      tick();
    end
    check("mux_count0", 64'(count), 64'd0);
    inst_bus[0 +: IW] = 32'h11111111;
    capture(2, 32'hDEADBEEF);
    inst_vld = '0;
    check("mux_count1", 64'(count), 64'd1);
    go = 1'b0;
    tick();
    drain(1, "mux");
    tick();
    check("mux_idle", 64'(state), 64'd0);

    // Reset mid-read.
    arm(3'd4);
    for (int i = 0; i < 8; i++) capture(4, 32'h400 + i);
    inst_vld = '0; go = 1'b0;
    tick();
    check("rmr_count", 64'(count), 64'd8);
    drain(1, "rmr");
    rd_req = 1'b1;
    reset  = 1'b0;
    tick();
    check("rmr_state", 64'(state), 64'd0);
    check("rmr_count0", 64'(count), 64'd0);
    check("rmr_rd_vld", 64'(rd_vld), 64'd0);
    reset = 1'b1; rd_req = 1'b0;
    sb.delete();
    tick();

`ifdef TRACE_TIMESTAMP_EN
    begin
      logic [15:0] t0;
      arm(3'd4);
      tick(); tick();
      capture(4, 32'h500);
      inst_vld = '0;
      tick(); tick(); tick();
      capture(4, 32'h501);
      inst_vld = '0; go = 1'b0;
      tick();
      drain(1, "ts0");
      t0 = rd_ts;
      drain(1, "ts1");
      check("ts_delta", 64'(rd_ts - t0), 64'd4);
      tick();
      check("ts_idle", 64'(state), 64'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
